// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: port indices and FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_arbiter_pkg;

    localparam int NPORTS    = 3;
    localparam int PORT_CPU  = 0;
    localparam int PORT_DISP = 1;
    localparam int PORT_KEY  = 2;

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Port index following the granted port, wrapping after the key port.
    function automatic logic [1:0] next_port(input logic [NPORTS-1:0] onehot);
        logic [1:0] nxt;
        nxt = 2'd0;
        if (onehot[PORT_CPU])  nxt = 2'd1;
        if (onehot[PORT_DISP]) nxt = 2'd2;
        if (onehot[PORT_KEY])  nxt = 2'd0;
        return nxt;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick3.sv
// Combinational 3-way priority pick, searching upward from a start index with wrap.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; non-picked requesters simply stay pending.
module rr_pick3
    import dmem_arbiter_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic [1:0]        start,
    output logic [NPORTS-1:0] gnt
);

    int   idx;
    logic found;

    // First requesting port at or after start wins; at most one bit set.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NPORTS; off++) begin
            idx = int'(start) + off;
            if (idx >= NPORTS) idx = idx - NPORTS;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter for CPU/display/key with a CPU lock; DMEM_ARB_RR_EN selects round-robin.
// Latency: grant same cycle as request, read data one cycle after grant.
// Backpressure: losers hold their request until granted; LOCKED blocks all but the CPU.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int LOCK_MAX = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS-1:0]    req_i,
    input  logic [NPORTS-1:0]    we_i,
    input  logic [NPORTS*AW-1:0] addr_i,
    input  logic [NPORTS*DW-1:0] wdata_i,
    input  logic                 cpu_lock_i,
    output logic [NPORTS-1:0]    gnt_o,
    output logic [NPORTS-1:0]    rvalid_o,
    output logic [DW-1:0]        rdata_o,
    output logic                 locked_o,
    output logic                 lock_err_o,
    output logic                 mem_en_o,
    output logic                 mem_we_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [DW-1:0]        mem_wdata_o,
    input  logic [DW-1:0]        mem_rdata_i
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    state_t            state;
    logic [CW-1:0]     lock_cnt;
    logic              lock_err;
    logic              lock_expired;
    logic [NPORTS-1:0] rvalid_q;
    logic [NPORTS-1:0] pick_gnt;
    logic [NPORTS-1:0] gnt;
    logic [1:0]        start;

`ifdef DMEM_ARB_RR_EN
    logic [1:0] rr_ptr;

    assign start = rr_ptr;

    // Pointer holds the port after the last winner; moves only when something is granted.
    always_ff @(posedge clk) begin
        if (reset)      rr_ptr <= 2'd0;
        else if (|gnt)  rr_ptr <= next_port(gnt);
    end
`else
    assign start = 2'd0;
`endif

    rr_pick3 u_pick (
        .req   (req_i),
        .start (start),
        .gnt   (pick_gnt)
    );

    // A lock that has run its full budget is released without granting the CPU.
    assign lock_expired = (state == LOCKED) && (lock_cnt == CW'(LOCK_MAX));

    // Open arbitration in OPEN, CPU-only in LOCKED, nothing while in reset.
    always_comb begin
        gnt = '0;
        if (!reset) begin
            if (state == OPEN)
                gnt = pick_gnt;
            else if (!lock_expired && req_i[PORT_CPU])
                gnt[PORT_CPU] = 1'b1;
        end
    end

    // Steer the winner onto the RAM port; everything reads as zero when idle.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (gnt[p]) begin
                mem_we_o    = we_i[p];
                mem_addr_o  = addr_i[p*AW +: AW];
                mem_wdata_o = wdata_i[p*DW +: DW];
            end
        end
    end

    // Lock FSM with its hold counter and the sticky forced-release flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= OPEN;
            lock_cnt <= '0;
            lock_err <= 1'b0;
        end else begin
            case (state)
                OPEN: begin
                    if (gnt[PORT_CPU] && cpu_lock_i) begin
                        state    <= LOCKED;
                        lock_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (lock_cnt != CW'(LOCK_MAX)) lock_cnt <= lock_cnt + 1'b1;
                    if (lock_expired) begin
                        state    <= OPEN;
                        lock_err <= 1'b1;
                    end else if (!cpu_lock_i) begin
                        // Covers both a final unlocked CPU grant and an idle unlock.
                        state <= OPEN;
                    end
                end
                default: state <= OPEN;
            endcase
        end
    end

    // Reads return to their owner one cycle after the grant; writes return nothing.
    always_ff @(posedge clk) begin
        if (reset) rvalid_q <= '0;
        else       rvalid_q <= gnt & ~we_i;
    end

    // A reset arriving in the return cycle kills the pending read strobe.
    assign rvalid_o   = rvalid_q & {NPORTS{~reset}};
    assign rdata_o    = mem_rdata_i;
    assign gnt_o      = gnt;
    assign mem_en_o   = |gnt;
    assign locked_o   = (state == LOCKED);
    assign lock_err_o = lock_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural sync RAM and a read-return scoreboard.
// Latency: expects grant in the request cycle and rvalid one cycle later.
// Backpressure: requesters hold until granted, as the arbiter expects.
module tb_dmem_arbiter;

    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int LOCK_MAX = 15;

    typedef struct {
        logic [2:0] port;
        logic [7:0] data;
    } rd_exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    req = '0;
    logic [2:0]    we = '0;
    logic [23:0]   addr = '0;
    logic [23:0]   wdata = '0;
    logic          cpu_lock = 1'b0;
    logic [2:0]    gnt_o;
    logic [2:0]    rvalid_o;
    logic [7:0]    rdata_o;
    logic          locked_o;
    logic          lock_err_o;
    logic          mem_en;
    logic          mem_we;
    logic [7:0]    mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = '0;

    logic [7:0]    ram [256];
    rd_exp_t       sb [$];
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .cpu_lock_i  (cpu_lock),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .locked_o    (locked_o),
        .lock_err_o  (lock_err_o),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    function automatic logic [7:0] iv(input logic [7:0] a);
        return a ^ 8'h4A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [7:0] a, input logic [7:0] d);
        req[p]         = r;
        we[p]          = w;
        addr[p*8 +: 8] = a;
        wdata[p*8 +: 8] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0; we = '0; cpu_lock = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // Synchronous single-port RAM with one-cycle read latency.
    initial for (int i = 0; i < 256; i++) ram[i] = iv(8'(i));
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Every read strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rvalid_o != 3'b000) begin
            if (sb.size() == 0) begin
                check("rv_spurious", {29'd0, rvalid_o}, 32'd0);
            end else begin
                rd_exp_t e;
                e = sb.pop_front();
                check("rv_port", {29'd0, rvalid_o}, {29'd0, e.port});
                check("rv_data", {24'd0, rdata_o}, {24'd0, e.data});
            end
        end
    end

    initial begin
        logic [1:0] m_ptr;
        logic [2:0] exp_g;
        int         lk_cycles;
        bit         released;

        // Reset state
        next_cycle();
        @(negedge clk);
        check("rst_gnt",    {29'd0, gnt_o}, 32'd0);
        check("rst_rvalid", {29'd0, rvalid_o}, 32'd0);
        check("rst_locked", {31'd0, locked_o}, 32'd0);
        check("rst_err",    {31'd0, lock_err_o}, 32'd0);
        check("rst_mem",    {15'd0, mem_en, mem_we, mem_addr, mem_wdata}, 32'd0);
        do_reset();

        // Single CPU read of 0x10
        set_port(0, 1'b1, 1'b0, 8'h10, 8'h00);
        sb.push_back('{port: 3'b001, data: 8'h5A});
        @(negedge clk);
        check("t1_gnt",  {29'd0, gnt_o}, 32'd1);
        check("t1_addr", {23'd0, mem_en, mem_addr}, {23'd0, 1'b1, 8'h10});
        next_cycle();
        req = '0;
        next_cycle();

        // All three ports requesting continuously
        do_reset();
        m_ptr = 2'd0;
        set_port(0, 1'b1, 1'b0, 8'h30, 8'h00);
        set_port(1, 1'b1, 1'b0, 8'h31, 8'h00);
        set_port(2, 1'b1, 1'b0, 8'h32, 8'h00);
        for (int c = 0; c < 6; c++) begin
`ifdef DMEM_ARB_RR_EN
            exp_g = 3'b001 << m_ptr;
            m_ptr = (m_ptr == 2'd2) ? 2'd0 : m_ptr + 2'd1;
`else
            exp_g = 3'b001;
`endif
            sb.push_back('{port: exp_g, data: iv(exp_g[0] ? 8'h30 : exp_g[1] ? 8'h31 : 8'h32)});
            @(negedge clk);
            check("t2_gnt", {29'd0, gnt_o}, {29'd0, exp_g});
            next_cycle();
        end
        req = '0;
        next_cycle();

        // Locked read-modify-write with display waiting
        do_reset();
        set_port(0, 1'b1, 1'b0, 8'h20, 8'h00);
        set_port(1, 1'b1, 1'b0, 8'h40, 8'h00);
        cpu_lock = 1'b1;
        sb.push_back('{port: 3'b001, data: iv(8'h20)});
        @(negedge clk);
        check("t3_gnt_a", {29'd0, gnt_o}, 32'd1);
        check("t3_lk_a",  {31'd0, locked_o}, 32'd0);
        next_cycle();
        req[0] = 1'b0;
        @(negedge clk);
        check("t3_gnt_b", {29'd0, gnt_o}, 32'd0);
        check("t3_lk_b",  {31'd0, locked_o}, 32'd1);
        next_cycle();
        set_port(0, 1'b1, 1'b1, 8'h20, 8'h77);
        cpu_lock = 1'b0;
        @(negedge clk);
        check("t3_gnt_c", {29'd0, gnt_o}, 32'd1);
        check("t3_wr_c",  {23'd0, mem_we, mem_wdata}, {23'd0, 1'b1, 8'h77});
        check("t3_lk_c",  {31'd0, locked_o}, 32'd1);
        next_cycle();
        req[0] = 1'b0; we[0] = 1'b0;
        sb.push_back('{port: 3'b010, data: iv(8'h40)});
        @(negedge clk);
        check("t3_gnt_d", {29'd0, gnt_o}, 32'd2);
        check("t3_lk_d",  {31'd0, locked_o}, 32'd0);
        next_cycle();
        req = '0;
        next_cycle();

        // Lock held with no CPU request until forced release
        do_reset();
        set_port(0, 1'b1, 1'b0, 8'h21, 8'h00);
        set_port(1, 1'b1, 1'b0, 8'h40, 8'h00);
        cpu_lock = 1'b1;
        sb.push_back('{port: 3'b001, data: iv(8'h21)});
        @(negedge clk);
        check("t4_gnt_a", {29'd0, gnt_o}, 32'd1);
        next_cycle();
        req[0] = 1'b0;
        @(negedge clk);
        check("t4_err_early", {31'd0, lock_err_o}, 32'd0);
        lk_cycles = 0;
        released  = 1'b0;
        for (int c = 0; c < 40 && !released; c++) begin
            if (c != 0) @(negedge clk);
            if (locked_o) begin
                lk_cycles++;
                check("t4_lk_nogrant", {29'd0, gnt_o}, 32'd0);
                next_cycle();
            end else begin
                released = 1'b1;
            end
        end
        if (!released) begin
            check("t4_timeout", 32'd0, 32'd1);
        end else begin
            sb.push_back('{port: 3'b010, data: iv(8'h40)});
            check("t4_lk_len", lk_cycles, LOCK_MAX + 1);
            check("t4_err",    {31'd0, lock_err_o}, 32'd1);
            check("t4_gnt_disp", {29'd0, gnt_o}, 32'd2);
        end
        next_cycle();
        req = '0;
        cpu_lock = 1'b0;
        next_cycle();

        // Key write then display read of the same address
        set_port(2, 1'b1, 1'b1, 8'hFF, 8'h03);
        @(negedge clk);
        check("t5_err_sticky", {31'd0, lock_err_o}, 32'd1);
        check("t5_gnt_key",    {29'd0, gnt_o}, 32'd4);
        check("t5_wr",         {22'd0, mem_we, mem_addr, mem_wdata}, {22'd0, 1'b1, 8'hFF, 8'h03});
        next_cycle();
        req[2] = 1'b0; we[2] = 1'b0;
        set_port(1, 1'b1, 1'b0, 8'hFF, 8'h00);
        sb.push_back('{port: 3'b010, data: 8'h03});
        @(negedge clk);
        check("t5_gnt_disp", {29'd0, gnt_o}, 32'd2);
        next_cycle();
        req = '0;
        next_cycle();
        next_cycle();

        // Reset in the cycle after a display read grant
        set_port(1, 1'b1, 1'b0, 8'h50, 8'h00);
        @(negedge clk);
        check("t6_gnt", {29'd0, gnt_o}, 32'd2);
        next_cycle();
        reset = 1'b1;
        req = '0;
        @(negedge clk);
        check("t6_rvalid", {29'd0, rvalid_o}, 32'd0);
        check("t6_locked", {31'd0, locked_o}, 32'd0);
        check("t6_err_clr_pending", {29'd0, gnt_o}, 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("t6_err_cleared", {31'd0, lock_err_o}, 32'd0);
        next_cycle();
        next_cycle();

        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data memory between three requesters: the CPU load/store path, the display scanner reading the board image, and the key-input writer that posts direction codes. It issues at most one memory access per cycle and routes read data back to the owner one cycle later. It supports a CPU lock so that snake-body read-modify-write sequences stay atomic. It sits between the control/datapath and the data RAM in the CPU top level.

## Interface
- AW, 8, memory address width
- DW, 8, memory data width
- LOCK_MAX, 15, maximum cycles a CPU lock may be held before forced release
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_i  in  3  request per port: [0] CPU, [1] display, [2] key
- we_i  in  3  write enable per port
- addr_i  in  3*AW  address per port, port n at [n*AW +: AW]
- wdata_i  in  3*DW  write data per port
- cpu_lock_i  in  1  CPU requests exclusive ownership after its grant
- gnt_o  out  3  one-hot grant, combinational, same cycle as the access
- rvalid_o  out  3  one-hot read-data valid, registered
- rdata_o  out  DW  read data, valid where rvalid_o is high
- locked_o  out  1  arbiter is in LOCKED state
- lock_err_o  out  1  sticky flag set by a forced lock release
- mem_en_o, mem_we_o  out  1 each  memory strobe and write enable
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  memory write data
- mem_rdata_i  in  DW  synchronous RAM output, one-cycle read latency

## Operation
- FSM states:
  - OPEN: any requesting port may be granted.
  - LOCKED: only the CPU may be granted.
- OPEN → LOCKED: the CPU is granted while cpu_lock_i=1.
- LOCKED → OPEN, on the first of these:
  - a CPU grant with cpu_lock_i=0;
  - a cycle with cpu_lock_i=0 and req_i[0]=0;
  - the lock counter reaching LOCK_MAX, which sets lock_err_o.
- Lock counter:
  - cleared on entry to LOCKED;
  - increments each cycle spent in LOCKED;
  - saturates at LOCK_MAX.
- Grant: at most one bit of gnt_o is high. Granting a port drives its we/addr/wdata onto the memory port with mem_en_o=1. mem_en_o=0 when no port is granted.
- Requesters hold req/we/addr/wdata stable until they are granted. Deasserting req before grant withdraws the request and is legal.
- A granted read raises rvalid_o[port] in the next cycle, and rdata_o=mem_rdata_i in that cycle.
- A granted write produces no rvalid_o.
- Back-to-back grants are allowed every cycle, including to the same port.
- Requesters must not issue a write and a read to the same address in the same cycle. This cannot occur, because only one port is granted per cycle.

## Timing
- Reset values:
  - state OPEN, counter 0, round-robin pointer 0;
  - gnt_o=0 (forced during reset), rvalid_o=0;
  - rdata_o follows mem_rdata_i and is don't-care;
  - locked_o=0, lock_err_o=0;
  - all mem_* outputs 0.
- Request-to-grant latency is 0 cycles when the port wins arbitration. Grant-to-read-data latency is 1 cycle.
- A reset asserted in the cycle after a read grant suppresses that rvalid_o.
- A forced lock release takes effect in the same cycle the counter reaches LOCK_MAX. In that cycle no CPU grant occurs. Open arbitration resumes the next cycle.
- lock_err_o clears only on reset.

## Configuration
- DMEM_ARB_RR_EN defined:
  - round-robin arbitration in OPEN;
  - the search starts at the port after the last granted port;
  - the pointer advances only on a grant.
- DMEM_ARB_RR_EN undefined: fixed priority CPU > display > key, and no pointer register.
- LOCKED behaviour is identical in both builds.

## Structure
- The shared package holds:
  - port index constants PORT_CPU=0, PORT_DISP=1, PORT_KEY=2, and NPORTS=3;
  - the state typedef {OPEN, LOCKED}.
- One sub-module, rr_pick3: a combinational 3-way priority pick given a start index. It is used with start=0 in the fixed-priority build.

## Test plan
- Reset, then a single CPU read of addr 0x10, with RAM holding 0x5A → gnt_o=001 in cycle 0; rvalid_o=001 and rdata_o=0x5A in cycle 1.
- All three ports requesting continuously, RR build → grants 001,010,100,001... One grant per cycle, no gaps. Fixed build → 001 every cycle.
- CPU read addr 0x20 with cpu_lock_i=1, then a write, with display requesting throughout → display is not granted until the CPU grant with lock=0. locked_o is high in between.
- CPU lock held with req_i[0]=0 for LOCK_MAX cycles → locked_o falls and lock_err_o=1. A pending display request is granted on the next cycle.
- Key write 0x03 to addr 0xFF, then a display read of 0xFF → no rvalid for the write; the display rvalid returns 0x03.
- Reset asserted in the cycle after a display read grant → rvalid_o=000 and state OPEN.
